// File: rtl/pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// pwm_multi_ch
//
// Multi-channel PWM generator. A shared prescaler produces a tick every
// prescale+1 clocks; a shared period counter advances on each tick, either
// edge-aligned (0..P, wrap) or center-aligned (0..P..1, repeat). Each channel
// compares the counter against its active duty value. Duty, period and mode
// are double-buffered: new values sit in shadow registers and are copied to
// the active set only at a period boundary, so a period is never cut short.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           run enable; low clears counters and outputs and keeps the
//                active set loaded from the shadow/live inputs every cycle
//   prescale     tick divider, used live
//   period       period top value, taken at a period boundary
//   center       0 = edge-aligned, 1 = center-aligned, taken at a boundary
//   wr_en        duty write strobe
//   wr_ch        channel index for the write (out-of-range indices ignored)
//   wr_duty      duty compare value
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse in the cycle after each period boundary
// -----------------------------------------------------------------------------
module pwm_multi_ch #(
    parameter  int CHANNELS = 4,
    parameter  int CNT_W    = 8,
    parameter  int PRE_W    = 16,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PRE_W-1:0]    prescale,
    input  logic [CNT_W-1:0]    period,
    input  logic                center,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;          // 1 = counting down (center mode)
    logic [CNT_W-1:0]    duty_pend_q [CHANNELS];
    logic [CNT_W-1:0]    duty_pend_d [CHANNELS];
    logic [CNT_W-1:0]    duty_act_q  [CHANNELS];
    logic [CNT_W-1:0]    duty_act_d  [CHANNELS];
    logic [CNT_W-1:0]    period_act_q, period_act_d;
    logic                center_act_q, center_act_d;
    logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
    logic                period_tick_q, period_tick_d;

    logic                tick_s;
    logic                boundary_s;
    logic [CNT_W-1:0]    cnt_step_s;
    logic                dir_step_s;

    // Prescaler: counts 0..prescale and flags the tick on the terminal value.
    always_comb begin
        tick_s    = 1'b0;
        pre_cnt_d = {PRE_W{1'b0}};
        if (en) begin
            if (pre_cnt_q == prescale) begin
                tick_s    = 1'b1;
                pre_cnt_d = {PRE_W{1'b0}};
            end else begin
                tick_s    = 1'b0;
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
        end else begin
            tick_s    = 1'b0;
            pre_cnt_d = {PRE_W{1'b0}};
        end
    end

    // Counter value and direction the counter would take on a tick.
    always_comb begin
        cnt_step_s = cnt_q;
        dir_step_s = dir_q;
        if (!center_act_q) begin
            dir_step_s = 1'b0;
            if (cnt_q == period_act_q) begin
                cnt_step_s = {CNT_W{1'b0}};
            end else begin
                cnt_step_s = cnt_q + CNT_W'(1);
            end
        end else if (period_act_q == {CNT_W{1'b0}}) begin
            // Degenerate center period: counter parks at 0.
            cnt_step_s = {CNT_W{1'b0}};
            dir_step_s = 1'b0;
        end else if (!dir_q) begin
            if (cnt_q == period_act_q) begin
                cnt_step_s = cnt_q - CNT_W'(1);
                dir_step_s = 1'b1;
            end else begin
                cnt_step_s = cnt_q + CNT_W'(1);
                dir_step_s = 1'b0;
            end
        end else begin
            cnt_step_s = cnt_q - CNT_W'(1);
            dir_step_s = 1'b1;
        end
    end

    // A boundary is any tick on which the counter returns to 0; this covers
    // the edge wrap, the center 1->0 step, P=1 center and P=0 in both modes.
    assign boundary_s = tick_s & (cnt_step_s == {CNT_W{1'b0}});

    // Counter, direction, active-set reload and period pulse.
    always_comb begin
        cnt_d         = cnt_q;
        dir_d         = dir_q;
        period_act_d  = period_act_q;
        center_act_d  = center_act_q;
        period_tick_d = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            duty_act_d[i] = duty_act_q[i];
        end
        if (!en) begin
            // Idle: hold counters at the start point and keep the active set
            // tracking so the first enabled period uses current settings.
            cnt_d         = {CNT_W{1'b0}};
            dir_d         = 1'b0;
            period_act_d  = period;
            center_act_d  = center;
            period_tick_d = 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act_d[i] = duty_pend_q[i];
            end
        end else if (tick_s) begin
            cnt_d         = cnt_step_s;
            period_tick_d = boundary_s;
            if (boundary_s) begin
                dir_d        = 1'b0;
                period_act_d = period;
                center_act_d = center;
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_act_d[i] = duty_pend_q[i];
                end
            end else begin
                dir_d        = dir_step_s;
                period_act_d = period_act_q;
                center_act_d = center_act_q;
            end
        end else begin
            cnt_d         = cnt_q;
            dir_d         = dir_q;
            period_tick_d = 1'b0;
        end
    end

    // Shadow duty registers; a write never touches the active set directly.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) begin
                duty_pend_d[i] = wr_duty;
            end else begin
                duty_pend_d[i] = duty_pend_q[i];
            end
        end
    end

    // Per-channel compare against the current counter value.
    always_comb begin
        pwm_out_d = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_out_d[i] = en & (cnt_q < duty_act_q[i]);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q     <= {PRE_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            dir_q         <= 1'b0;
            period_act_q  <= {CNT_W{1'b0}};
            center_act_q  <= 1'b0;
            pwm_out_q     <= {CHANNELS{1'b0}};
            period_tick_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_pend_q[i] <= {CNT_W{1'b0}};
                duty_act_q[i]  <= {CNT_W{1'b0}};
            end
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            period_act_q  <= period_act_d;
            center_act_q  <= center_act_d;
            pwm_out_q     <= pwm_out_d;
            period_tick_q <= period_tick_d;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_pend_q[i] <= duty_pend_d[i];
                duty_act_q[i]  <= duty_act_d[i];
            end
        end
    end

    assign pwm_out     = pwm_out_q;
    assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_ch
//
// Bench for pwm_multi_ch with five channels (so a 3-bit channel select has
// unused codes 5..7). A reference model tracks the position within the
// current period and derives the counter from it; its outputs are compared
// every cycle. Table vectors measure high time and period length per setup,
// and short hand-written sequences cover shadow update, mode switching,
// ignored channel writes and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pwm_multi_ch;

    localparam int NCH = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] prescale = 16'd0;
    logic [7:0]  period = 8'd0;
    logic        center = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_ch = 3'd0;
    logic [7:0]  wr_duty = 8'd0;
    logic [NCH-1:0] pwm_out;
    logic        period_tick;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    pwm_multi_ch #(.CHANNELS(NCH), .CNT_W(8), .PRE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale),
        .period(period), .center(center), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .pwm_out(pwm_out), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0]    m_pre;
    int             m_pos;        // position within the current period, in ticks
    logic [7:0]     m_pact;
    logic           m_cact;
    logic [7:0]     m_pend [NCH];
    logic [7:0]     m_act  [NCH];
    logic [NCH-1:0] m_pwm;
    logic           m_tick;

    function automatic int m_len();
        if (m_cact) return (m_pact == 8'd0) ? 1 : 2 * int'(m_pact);
        else        return int'(m_pact) + 1;
    endfunction

    function automatic int m_cnt();
        if (m_cact && m_pos > int'(m_pact)) return 2 * int'(m_pact) - m_pos;
        else                                 return m_pos;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre = 16'd0; m_pos = 0; m_pact = 8'd0; m_cact = 1'b0;
            m_pwm = '0; m_tick = 1'b0;
            for (int i = 0; i < NCH; i++) begin m_pend[i] = 8'd0; m_act[i] = 8'd0; end
        end else begin
            logic [NCH-1:0] pn;
            bit tk, bnd;
            int c, len;
            c = m_cnt();
            len = m_len();
            for (int i = 0; i < NCH; i++) pn[i] = en && (c < int'(m_act[i]));
            tk = en && (m_pre == prescale);
            bnd = 1'b0;
            if (!en) begin
                m_pre = 16'd0; m_pos = 0;
                bnd = 1'b1;            // reload happens every idle cycle
            end else begin
                m_pre = tk ? 16'd0 : m_pre + 16'd1;
                if (tk) begin
                    m_pos++;
                    if (m_pos >= len) begin m_pos = 0; bnd = 1'b1; end
                end
            end
            if (bnd) begin
                for (int i = 0; i < NCH; i++) m_act[i] = m_pend[i];
                m_pact = period; m_cact = center;
            end
            m_tick = en && bnd;
            if (wr_en && int'(wr_ch) < NCH) m_pend[wr_ch] = wr_duty;
            m_pwm = pn;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_pwm", pwm_out, m_pwm);
            check("model_tick", period_tick, m_tick);
        end
    end

    // ---------------- helpers ----------------
    typedef struct packed {
        logic [15:0]       pre;
        logic [7:0]        per;
        logic              cen;
        logic [4:0][7:0]   d;
        logic [4:0][15:0]  hi;
        logic [15:0]       len;
    } vec_t;

    function automatic vec_t mk(int pre, int per, bit cen, int d0, int d1, int d2, int d3,
                                int h0, int h1, int h2, int h3, int len);
        vec_t v;
        v.pre = 16'(pre); v.per = 8'(per); v.cen = cen; v.len = 16'(len);
        v.d[0] = 8'(d0); v.d[1] = 8'(d1); v.d[2] = 8'(d2); v.d[3] = 8'(d3); v.d[4] = 8'd0;
        v.hi[0] = 16'(h0); v.hi[1] = 16'(h1); v.hi[2] = 16'(h2); v.hi[3] = 16'(h3); v.hi[4] = 16'd0;
        return v;
    endfunction

    // Called at a negedge; leaves the bench at a later negedge.
    task automatic wr(input int ch, input int d);
        wr_en = 1'b1; wr_ch = 3'(ch); wr_duty = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic cfg(input int pre, input int per, input bit cen, input logic [4:0][7:0] d);
        @(negedge clk);
        en = 1'b0; prescale = 16'(pre); period = 8'(per); center = cen;
        for (int ch = 0; ch < NCH; ch++) wr(ch, int'(d[ch]));
        @(negedge clk);                // one idle cycle copies shadows to active
        en = 1'b1;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (period_tick === 1'b1) begin ok = 1'b1; return; end
        end
        total++; bad++;
        $display("FAIL wait_tick: no period_tick within 3000 cycles at %0t", $time);
    endtask

    vec_t tbl [5];

    initial begin
        bit ok;
        int h [NCH];
        int nt, t1, t2;
        logic [4:0][7:0] dz;

        tbl[0] = mk(0, 9, 1'b0,  0, 3, 10, 12,   0, 3, 10, 10,  10);
        tbl[1] = mk(3, 4, 1'b0,  2, 0,  5,  1,   8, 0, 20,  4,  20);
        tbl[2] = mk(0, 8, 1'b1,  4, 0,  9,  1,   7, 0, 16,  1,  16);
        tbl[3] = mk(0, 0, 1'b0,  1, 0, 255, 0,   1, 0,  1,  0,   1);
        tbl[4] = mk(1, 3, 1'b1,  2, 3,  4,  0,   6, 10, 12, 0,  12);

        // Reset and idle.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_pwm", pwm_out, 0);
            check("rst_tick", period_tick, 0);
        end
        chk_on = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 2) begin wr_en = 1'b1; wr_ch = 3'd0; wr_duty = 8'd5; end
            else wr_en = 1'b0;
            @(negedge clk);
            check("idle_pwm", pwm_out, 0);
            check("idle_tick", period_tick, 0);
        end

        // Table vectors: high time per channel and period length.
        for (int v = 0; v < 5; v++) begin
            cfg(int'(tbl[v].pre), int'(tbl[v].per), tbl[v].cen, tbl[v].d);
            wait_tick(ok);
            if (ok) begin
                for (int ch = 0; ch < NCH; ch++) h[ch] = 0;
                nt = 0; t1 = 0;
                for (int k = 1; k <= int'(tbl[v].len); k++) begin
                    @(negedge clk);
                    for (int ch = 0; ch < NCH; ch++) h[ch] += int'(pwm_out[ch]);
                    if (period_tick === 1'b1) begin nt++; t1 = k; end
                end
                for (int ch = 0; ch < NCH; ch++)
                    check($sformatf("vec%0d_high_ch%0d", v, ch), h[ch], tbl[v].hi[ch]);
                check($sformatf("vec%0d_tick_count", v), nt, 1);
                check($sformatf("vec%0d_tick_pos", v), t1, tbl[v].len);
            end
        end

        // Shadow update: mid-period write then a write in the boundary cycle.
        dz = '0; dz[1] = 8'd3;
        cfg(0, 9, 1'b0, dz);
        wait_tick(ok);
        if (ok) begin
            int hb [3];
            for (int j = 0; j < 3; j++) hb[j] = 0;
            for (int k = 1; k <= 30; k++) begin
                if (k == 4)       begin wr_en = 1'b1; wr_ch = 3'd1; wr_duty = 8'd7; end
                else if (k == 10) begin wr_en = 1'b1; wr_ch = 3'd1; wr_duty = 8'd5; end
                else wr_en = 1'b0;
                @(negedge clk);
                hb[(k - 1) / 10] += int'(pwm_out[1]);
            end
            check("shadow_cur", hb[0], 3);
            check("shadow_next", hb[1], 7);
            check("shadow_follow", hb[2], 5);
        end

        // Center mode, then switch to edge mid-period.
        dz = '0; dz[0] = 8'd4;
        cfg(0, 8, 1'b1, dz);
        wait_tick(ok);
        if (ok) begin
            int hc0, hc1;
            hc0 = 0; hc1 = 0; t1 = -1; t2 = -1;
            for (int k = 1; k <= 25; k++) begin
                if (k == 4) center = 1'b0;
                @(negedge clk);
                if (k <= 16) hc0 += int'(pwm_out[0]); else hc1 += int'(pwm_out[0]);
                if (period_tick === 1'b1) begin
                    if (t1 < 0) t1 = k; else if (t2 < 0) t2 = k;
                end
            end
            check("center_period", t1, 16);
            check("center_high", hc0, 7);
            check("switch_period", t2, 25);
            check("switch_high", hc1, 4);
        end

        // Out-of-range channel writes are ignored.
        dz = '0;
        cfg(0, 3, 1'b0, dz);
        wr(5, 255); wr(6, 255); wr(7, 255);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("ignored_ch_pwm", pwm_out, 0);
        end

        // Asynchronous reset mid-period.
        dz = '0; dz[0] = 8'd10;
        cfg(0, 9, 1'b0, dz);
        repeat (5) @(negedge clk);
        check("pre_reset_high", pwm_out[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm", pwm_out, 0);
        check("async_rst_tick", period_tick, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized segments against the model.
        for (int seg = 0; seg < 8; seg++) begin
            @(negedge clk);
            en = 1'b0;
            prescale = 16'($urandom_range(0, 3));
            period = (seg == 7) ? 8'd255 : 8'($urandom_range(0, 12));
            center = 1'($urandom_range(0, 1));
            @(negedge clk);
            en = 1'b1;
            for (int c = 0; c < 300; c++) begin
                wr_en = ($urandom_range(0, 3) == 0);
                wr_ch = 3'($urandom_range(0, 7));
                wr_duty = 8'($urandom_range(0, int'(period) + 2));
                if ($urandom_range(0, 49) == 0) period = 8'($urandom_range(0, 12));
                if ($urandom_range(0, 49) == 0) center = ~center;
                if ($urandom_range(0, 99) == 0) en = ~en;
                @(negedge clk);
            end
            wr_en = 1'b0;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
